// File: rtl/red_pitaya_limit_multi_pkg.sv
// Shared types and helpers for the multi-channel output limiter.
// Rail FSM encoding, railed-bit indices and a saturating increment.
package red_pitaya_limit_multi_pkg;

    typedef enum logic [2:0] {
        IN_RANGE = 3'd0,
        RAIL_LO  = 3'd1,
        RAIL_HI  = 3'd2,
        HOLD_LO  = 3'd3,
        HOLD_HI  = 3'd4
    } rail_state_e;

    localparam int RAIL_LO_BIT = 0;
    localparam int RAIL_HI_BIT = 1;

    // Counters up to 32 bits wide; callers cast the result back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? vmax : v + 32'd1;
    endfunction

endpackage

// File: rtl/red_pitaya_limit_multi_if.sv
// Sample/limit/status bundle between the control path and the limiter.
// Optional slew_i exists only when LIMIT_SLEW_EN is defined.
interface red_pitaya_limit_multi_if #(
    parameter int DW     = 14,
    parameter int CH     = 2,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
);
    logic [CH*DW-1:0]    min_val_i;
    logic [CH*DW-1:0]    max_val_i;
    logic [CH*DW-1:0]    signal_i;
`ifdef LIMIT_SLEW_EN
    logic [CH*DW-1:0]    slew_i;
`endif
    logic [HOLD_W-1:0]   hold_i;
    logic [CH-1:0]       clr_i;
    logic [CH*DW-1:0]    signal_o;
    logic [2*CH-1:0]     railed_o;
    logic [2*CH-1:0]     sticky_o;
    logic [CH*CNT_W-1:0] rail_cnt_o;

    modport master (
        output min_val_i, max_val_i, signal_i,
`ifdef LIMIT_SLEW_EN
        output slew_i,
`endif
        output hold_i, clr_i,
        input  signal_o, railed_o, sticky_o, rail_cnt_o
    );

    modport slave (
        input  min_val_i, max_val_i, signal_i,
`ifdef LIMIT_SLEW_EN
        input  slew_i,
`endif
        input  hold_i, clr_i,
        output signal_o, railed_o, sticky_o, rail_cnt_o
    );
endinterface

// File: rtl/red_pitaya_limit_chan.sv
// One limiter channel: clamp, rail FSM with hold-off, sticky flags, rail counter.
// Latency 1 cycle (registered); no backpressure. LIMIT_SLEW_EN adds output slew limiting.
module red_pitaya_limit_chan
    import red_pitaya_limit_multi_pkg::*;
#(
    parameter int DW     = 14,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic signed [DW-1:0] sample,
    input  logic signed [DW-1:0] min_val,
    input  logic signed [DW-1:0] max_val,
`ifdef LIMIT_SLEW_EN
    input  logic [DW-1:0]        slew,
`endif
    input  logic [HOLD_W-1:0]    hold,
    input  logic                 clr,
    output logic signed [DW-1:0] y,
    output logic [1:0]           railed,
    output logic [1:0]           sticky,
    output logic [CNT_W-1:0]     rail_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 over_hi, under_lo;
    logic signed [DW-1:0] target, y_q, y_next;
    rail_state_e          state_q, state_d;
    logic [HOLD_W-1:0]    hcnt_q, hcnt_d;
    logic [1:0]           entry, sticky_q;
    logic [CNT_W-1:0]     cnt_q, cnt_base;

    // Max test first so a min > max window resolves deterministically to max.
    always_comb begin
        over_hi  = sample > max_val;
        under_lo = !over_hi && (sample < min_val);
        target   = over_hi ? max_val : (under_lo ? min_val : sample);
    end

`ifdef LIMIT_SLEW_EN
    logic signed [DW:0] diff, stepped;
    logic        [DW:0] mag;
    logic signed [DW-1:0] cand;
    always_comb begin
        diff    = {target[DW-1], target} - {y_q[DW-1], y_q};
        mag     = diff[DW] ? -diff : diff;
        stepped = diff[DW] ? ({y_q[DW-1], y_q} - $signed({1'b0, slew}))
                           : ({y_q[DW-1], y_q} + $signed({1'b0, slew}));
        cand    = stepped[DW-1:0];
        y_next  = target;
        // Re-clamp the stepped value so a limit change never leaves y outside the window.
        if (slew != '0 && mag > {1'b0, slew})
            y_next = (cand > max_val) ? max_val : ((cand < min_val) ? min_val : cand);
    end
`else
    assign y_next = target;
`endif

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        entry   = 2'b00;
        case (state_q)
            IN_RANGE: begin
                if (over_hi) begin
                    state_d = RAIL_HI;
                    entry[RAIL_HI_BIT] = 1'b1;
                end else if (under_lo) begin
                    state_d = RAIL_LO;
                    entry[RAIL_LO_BIT] = 1'b1;
                end
            end
            RAIL_HI, HOLD_HI: begin
                if (over_hi) begin
                    state_d = RAIL_HI;
                end else if (under_lo) begin
                    state_d = RAIL_LO;
                    entry[RAIL_LO_BIT] = 1'b1;
                end else if (state_q == RAIL_HI) begin
                    state_d = (hold == '0) ? IN_RANGE : HOLD_HI;
                    hcnt_d  = hold;
                end else if (hcnt_q <= HOLD_W'(1)) begin
                    state_d = IN_RANGE;
                end else begin
                    hcnt_d = hcnt_q - HOLD_W'(1);
                end
            end
            RAIL_LO, HOLD_LO: begin
                if (under_lo) begin
                    state_d = RAIL_LO;
                end else if (over_hi) begin
                    state_d = RAIL_HI;
                    entry[RAIL_HI_BIT] = 1'b1;
                end else if (state_q == RAIL_LO) begin
                    state_d = (hold == '0) ? IN_RANGE : HOLD_LO;
                    hcnt_d  = hold;
                end else if (hcnt_q <= HOLD_W'(1)) begin
                    state_d = IN_RANGE;
                end else begin
                    hcnt_d = hcnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IN_RANGE;
        endcase
    end

    // A clear coinciding with an entry yields count 1 and the new sticky bit.
    assign cnt_base = clr ? '0 : cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IN_RANGE;
            hcnt_q   <= '0;
            y_q      <= '0;
            sticky_q <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            y_q      <= y_next;
            sticky_q <= (clr ? 2'b00 : sticky_q) | entry;
            cnt_q    <= (|entry) ? CNT_W'(sat_inc(32'(cnt_base), 32'(CNT_MAX))) : cnt_base;
        end
    end

    always_comb begin
        railed = 2'b00;
        railed[RAIL_LO_BIT] = (state_q == RAIL_LO) || (state_q == HOLD_LO);
        railed[RAIL_HI_BIT] = (state_q == RAIL_HI) || (state_q == HOLD_HI);
    end

    assign y        = y_q;
    assign sticky   = sticky_q;
    assign rail_cnt = cnt_q;

endmodule

// File: rtl/red_pitaya_limit_multi.sv
// Multi-channel output limiter: per-channel clamp, rail FSM, sticky flags, counters.
// Latency 1 cycle; no backpressure (accepts a sample every cycle). Option: LIMIT_SLEW_EN.
module red_pitaya_limit_multi
    import red_pitaya_limit_multi_pkg::*;
#(
    parameter int DW     = 14,
    parameter int CH     = 2,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    red_pitaya_limit_multi_if.slave  bus
);
    for (genvar n = 0; n < CH; n++) begin : g_chan
        red_pitaya_limit_chan #(
            .DW     (DW),
            .HOLD_W (HOLD_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .sample   (bus.signal_i[n*DW +: DW]),
            .min_val  (bus.min_val_i[n*DW +: DW]),
            .max_val  (bus.max_val_i[n*DW +: DW]),
`ifdef LIMIT_SLEW_EN
            .slew     (bus.slew_i[n*DW +: DW]),
`endif
            .hold     (bus.hold_i),
            .clr      (bus.clr_i[n]),
            .y        (bus.signal_o[n*DW +: DW]),
            .railed   (bus.railed_o[2*n +: 2]),
            .sticky   (bus.sticky_o[2*n +: 2]),
            .rail_cnt (bus.rail_cnt_o[n*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_red_pitaya_limit_multi.sv
// Scoreboard bench for red_pitaya_limit_multi: a behavioural model pushes expected
// outputs per applied sample; they are popped and compared one cycle later.
module tb_red_pitaya_limit_multi;
    localparam int DW = 14, CH = 2, HOLD_W = 8, CNT_W = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef struct {
        logic [CH*DW-1:0]    sig;
        logic [2*CH-1:0]     railed;
        logic [2*CH-1:0]     sticky;
        logic [CH*CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    red_pitaya_limit_multi_if #(.DW(DW), .CH(CH), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus ();

    red_pitaya_limit_multi #(.DW(DW), .CH(CH), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

`ifdef LIMIT_SLEW_EN
    initial bus.slew_i = '0;
`endif

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];

    // stimulus
    int mn[CH], mx[CH], x[CH];
    int hold;
    bit [CH-1:0] clr;

    // reference model state
    int m_side[CH];   // 0 in range, 1 low side, 2 high side
    bit m_rail[CH];   // 1 while actively railed, 0 while in hold-off
    int m_hrem[CH];
    int m_cnt[CH];
    bit [1:0] m_sticky[CH];
    int m_y[CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_side[c] = 0; m_rail[c] = 0; m_hrem[c] = 0;
            m_cnt[c] = 0; m_sticky[c] = 2'b00; m_y[c] = 0;
        end
    endtask

    task automatic model_step(output exp_t e);
        bit hi, lo, e_hi, e_lo;
        for (int c = 0; c < CH; c++) begin
            hi = x[c] > mx[c];
            lo = !hi && (x[c] < mn[c]);
            m_y[c] = hi ? mx[c] : (lo ? mn[c] : x[c]);
            e_hi = hi && (m_side[c] != 2);
            e_lo = lo && (m_side[c] != 1);
            if (hi || lo) begin
                m_side[c] = hi ? 2 : 1;
                m_rail[c] = 1;
            end else if (m_side[c] != 0) begin
                if (m_rail[c]) begin
                    if (hold == 0) m_side[c] = 0;
                    else begin m_rail[c] = 0; m_hrem[c] = hold; end
                end else if (m_hrem[c] <= 1) m_side[c] = 0;
                else m_hrem[c]--;
            end
            if (clr[c]) begin m_cnt[c] = 0; m_sticky[c] = 2'b00; end
            if (e_hi || e_lo) begin
                if (m_cnt[c] < CNT_SAT) m_cnt[c]++;
                m_sticky[c] = m_sticky[c] | {e_hi, e_lo};
            end
            e.sig[c*DW +: DW]       = m_y[c][DW-1:0];
            e.railed[2*c +: 2]      = {m_side[c] == 2, m_side[c] == 1};
            e.sticky[2*c +: 2]      = m_sticky[c];
            e.cnt[c*CNT_W +: CNT_W] = m_cnt[c][CNT_W-1:0];
        end
    endtask

    // Drive one sample set, predict, wait one edge, compare.
    task automatic cyc(input string tag);
        exp_t e, g;
        for (int c = 0; c < CH; c++) begin
            bus.min_val_i[c*DW +: DW] = mn[c][DW-1:0];
            bus.max_val_i[c*DW +: DW] = mx[c][DW-1:0];
            bus.signal_i[c*DW +: DW]  = x[c][DW-1:0];
        end
        bus.hold_i = hold[HOLD_W-1:0];
        bus.clr_i  = clr;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, ".sig"},    64'(bus.signal_o),   64'(g.sig));
        chk({tag, ".railed"}, 64'(bus.railed_o),   64'(g.railed));
        chk({tag, ".sticky"}, 64'(bus.sticky_o),   64'(g.sticky));
        chk({tag, ".cnt"},    64'(bus.rail_cnt_o), 64'(g.cnt));
        clr = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sig"},    64'(bus.signal_o),   64'd0);
        chk({tag, ".railed"}, 64'(bus.railed_o),   64'd0);
        chk({tag, ".sticky"}, 64'(bus.sticky_o),   64'd0);
        chk({tag, ".cnt"},    64'(bus.rail_cnt_o), 64'd0);
    endtask

    initial begin
        int basic[4] = '{0, 5000, -5000, 4000};
        int hseq[15] = '{5000, 5000, 0, 0, 0, 0, 0, 5000, 0, 0, 5000, 0, 0, 0, 0};
        int mis[3]   = '{6000, 0, -3000};
        int rseq[6]  = '{5000, 0, 5000, 0, 5000, 5000};

        rstn = 1'b0;
        for (int c = 0; c < CH; c++) begin mn[c] = -4000; mx[c] = 4000; x[c] = 0; end
        hold = 0; clr = '0;
        bus.min_val_i = '0; bus.max_val_i = '0; bus.signal_i = '0;
        bus.hold_i = '0; bus.clr_i = '0;
        model_reset();
        #22;
        chk_zero("reset");
        rstn = 1'b1;

        // basic clamp, ch1 parked in range
        x[1] = 100;
        foreach (basic[i]) begin x[0] = basic[i]; cyc("basic"); end
        x[0] = -4000; cyc("basic_min_edge");

        // hold-off with re-rail inside hold window
        hold = 3;
        foreach (hseq[i]) begin x[0] = hseq[i]; cyc("hold"); end

        // misconfigured window (min > max)
        hold = 0; mn[0] = 1000; mx[0] = -2000;
        foreach (mis[i]) begin x[0] = mis[i]; cyc("misconfig"); end
        mn[0] = -4000; mx[0] = 4000; x[0] = 0; cyc("restore");

        // counter saturation, then clear coinciding with an entry, then plain clear
        for (int i = 0; i < 20; i++) begin x[0] = (i % 2 == 0) ? 5000 : -5000; cyc("sat"); end
        x[0] = 0; cyc("sat_exit");
        x[0] = 5000; clr = 2'b01; cyc("clr_entry");
        x[0] = 0; clr = 2'b01; cyc("clr_plain");

        // randomised mix on both channels
        mn[1] = -1000; mx[1] = 3000;
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < CH; c++) x[c] = int'($urandom_range(12000)) - 6000;
            hold = int'($urandom_range(3));
            clr  = ($urandom_range(7) == 0) ? CH'($urandom_range(3)) : '0;
            cyc("rand");
        end

        // reset mid-operation with ch0 railed high
        hold = 0; mn[1] = -4000; mx[1] = 4000; x[1] = 0;
        for (int c = 0; c < CH; c++) cyc("pre_rst_settle");
        foreach (rseq[i]) begin x[0] = rseq[i]; cyc("pre_rst"); end
        #3;
        rstn = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        x[0] = 0; cyc("post_rst_idle");
        x[0] = 5000; cyc("post_rst_entry");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
